// File: rtl/snn_pkg.sv
// Shared constants, state encoding and pool-tag payload for the SNN sequencing controller.
package snn_pkg;

  localparam int unsigned IMG_DIM   = 6;
  localparam int unsigned CONV_DIM  = 4;
  localparam int unsigned N_BEATS   = 72;
  localparam int unsigned KER_BEATS = 9;
  localparam int unsigned W_BEATS   = 4;
  localparam int unsigned IMG_PIX   = IMG_DIM * IMG_DIM;

  localparam int unsigned CNT_W   = 7;
  localparam int unsigned PIX_W   = 6;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned POS_W   = 4;
  localparam int unsigned KIDX_W  = 4;
  localparam int unsigned WIDX_W  = 2;
  localparam int unsigned QUAD_W  = 2;
  localparam int unsigned DIST_W  = 10;

  // Conv positions whose result completes a 2x2 pooling quadrant
  localparam logic [POS_W-1:0] POOL_POS_Q0 = 4'd5;
  localparam logic [POS_W-1:0] POOL_POS_Q1 = 4'd7;
  localparam logic [POS_W-1:0] POOL_POS_Q2 = 4'd13;
  localparam logic [POS_W-1:0] POOL_POS_Q3 = 4'd15;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  typedef struct packed {
    logic              go;
    logic [QUAD_W-1:0] quad;
    logic              img;
  } pool_tag_t;

  // Returns {hit, quad} for a conv position
  function automatic logic [QUAD_W:0] pool_lookup(input logic [POS_W-1:0] pos);
    case (pos)
      POOL_POS_Q0: return 3'b100;
      POOL_POS_Q1: return 3'b101;
      POOL_POS_Q2: return 3'b110;
      POOL_POS_Q3: return 3'b111;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/snn_delay_line.sv
// Fixed-depth shift register with synchronous clear, used to align strobes to datapath latency.
module snn_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/snn_ctrl.sv
// Beat counter and FSM that sequences storage writes and conv/pool/FC/distance strobes
// for one 72-beat frame, then presents the final distance for a single cycle.
module snn_ctrl
  import snn_pkg::*;
#(
  parameter int unsigned CONV_LAT = 2,
  parameter int unsigned TAIL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIST_W-1:0]  dist_in,
  output logic               img_we,
  output logic               img_sel,
  output logic [COORD_W-1:0] img_row,
  output logic [COORD_W-1:0] img_col,
  output logic               ker_we,
  output logic [KIDX_W-1:0]  ker_idx,
  output logic               w_we,
  output logic [WIDX_W-1:0]  w_idx,
  output logic               conv_go,
  output logic [POS_W-1:0]   conv_pos,
  output logic               conv_img,
  output logic               pool_go,
  output logic [QUAD_W-1:0]  pool_quad,
  output logic               pool_img,
  output logic               fc_go,
  output logic               dist_go,
  output logic               out_valid,
  output logic [DIST_W-1:0]  out_data
);

  localparam int unsigned DRAIN_CYC = CONV_LAT + TAIL_LAT;
  localparam int unsigned DRN_W     = $clog2(DRAIN_CYC + 1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DRN_W-1:0]    r_drain;
  logic                r_conv_go, r_conv_img, r_dist_go, r_out_valid;
  logic [POS_W-1:0]    r_conv_pos;
  logic [DIST_W-1:0]   r_out_data;

  logic                w_accept, w_beat, w_last, w_sel, w_win;
  logic [PIX_W-1:0]    w_pix;
  logic [COORD_W-1:0]  w_row, w_col;
  logic [POS_W-1:0]    w_pos;
  logic [QUAD_W:0]     w_lookup;
  pool_tag_t           w_tag_in, w_tag_out;

  assign w_accept = (r_state == IDLE) || (r_state == LOAD);
  assign w_beat   = in_valid && w_accept && !rst;
  assign w_last   = (r_cnt == CNT_W'(N_BEATS - 1));

  // Beat count -> image select, pixel coordinate and conv window position
  always_comb begin
    w_sel = (r_cnt >= CNT_W'(IMG_PIX));
    w_pix = w_sel ? PIX_W'(r_cnt - CNT_W'(IMG_PIX)) : PIX_W'(r_cnt);
    w_row = COORD_W'(w_pix / PIX_W'(IMG_DIM));
    w_col = COORD_W'(w_pix % PIX_W'(IMG_DIM));
    w_win = (w_row >= COORD_W'(2)) && (w_col >= COORD_W'(2));
    w_pos = POS_W'((32'(w_row) - 32'd2) * CONV_DIM + (32'(w_col) - 32'd2));
  end

  assign img_we  = w_beat;
  assign img_sel = w_beat && w_sel;
  assign img_row = w_beat ? w_row : '0;
  assign img_col = w_beat ? w_col : '0;
  assign ker_we  = w_beat && (r_cnt < CNT_W'(KER_BEATS));
  assign ker_idx = ker_we ? KIDX_W'(r_cnt) : '0;
  assign w_we    = w_beat && (r_cnt < CNT_W'(W_BEATS));
  assign w_idx   = w_we ? WIDX_W'(r_cnt) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_beat) w_state_nxt = LOAD;
      LOAD:    if (w_beat && w_last) w_state_nxt = DRAIN;
      DRAIN:   if (r_drain == DRN_W'(DRAIN_CYC - 1)) w_state_nxt = OUT;
      OUT:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_conv_go   <= 1'b0;
      r_conv_pos  <= '0;
      r_conv_img  <= 1'b0;
      r_dist_go   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_beat) r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      r_drain     <= (r_state == DRAIN) ? r_drain + DRN_W'(1) : '0;
      r_conv_go   <= w_beat && w_win;
      r_conv_pos  <= (w_beat && w_win) ? w_pos : '0;
      r_conv_img  <= w_beat && w_win && w_sel;
      r_dist_go   <= fc_go && pool_img;
      r_out_valid <= (w_state_nxt == OUT);
      r_out_data  <= (w_state_nxt == OUT) ? dist_in : '0;
    end
  end

  // Quadrant-completing conv results travel down the conv latency to become pool strobes
  always_comb begin
    w_lookup      = pool_lookup(r_conv_pos);
    w_tag_in.go   = r_conv_go && w_lookup[QUAD_W];
    w_tag_in.quad = w_lookup[QUAD_W-1:0];
    w_tag_in.img  = r_conv_img;
  end

  snn_delay_line #(
    .DEPTH(CONV_LAT),
    .WIDTH($bits(pool_tag_t))
  ) u_pool_dly (
    .clk  (clk),
    .i_clr(rst),
    .i_d  (w_tag_in),
    .o_q  (w_tag_out)
  );

  assign conv_go   = r_conv_go;
  assign conv_pos  = r_conv_pos;
  assign conv_img  = r_conv_img;
  assign pool_go   = w_tag_out.go;
  assign pool_quad = w_tag_out.quad;
  assign pool_img  = w_tag_out.img;
  assign fc_go     = pool_go && (pool_quad == QUAD_W'(3));
  assign dist_go   = r_dist_go;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_snn_ctrl.sv
// Scoreboard bench for snn_ctrl: default latencies on dut0, CONV_LAT=4/TAIL_LAT=2 on dut1.
module tb_snn_ctrl;

  localparam int K_WR   = 0;
  localparam int K_CONV = 1;
  localparam int K_POOL = 2;
  localparam int K_FC   = 3;
  localparam int K_DIST = 4;
  localparam int K_OUT  = 5;

  typedef struct {
    int          cyc;
    logic [14:0] pay;
  } exp_t;

  logic             clk, rst;
  logic [1:0]       iv;
  logic [1:0][9:0]  dist_in;
  logic [1:0]       img_we, img_sel, ker_we, w_we, conv_go, conv_img;
  logic [1:0]       pool_go, pool_img, fc_go, dist_go, out_valid;
  logic [1:0][2:0]  img_row, img_col;
  logic [1:0][3:0]  ker_idx, conv_pos;
  logic [1:0][1:0]  w_idx, pool_quad;
  logic [1:0][9:0]  out_data;

  exp_t q [2][6][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 0;

  snn_ctrl u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .dist_in(dist_in[0]),
    .img_we(img_we[0]), .img_sel(img_sel[0]), .img_row(img_row[0]), .img_col(img_col[0]),
    .ker_we(ker_we[0]), .ker_idx(ker_idx[0]), .w_we(w_we[0]), .w_idx(w_idx[0]),
    .conv_go(conv_go[0]), .conv_pos(conv_pos[0]), .conv_img(conv_img[0]),
    .pool_go(pool_go[0]), .pool_quad(pool_quad[0]), .pool_img(pool_img[0]),
    .fc_go(fc_go[0]), .dist_go(dist_go[0]), .out_valid(out_valid[0]), .out_data(out_data[0])
  );

  snn_ctrl #(.CONV_LAT(4), .TAIL_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .dist_in(dist_in[1]),
    .img_we(img_we[1]), .img_sel(img_sel[1]), .img_row(img_row[1]), .img_col(img_col[1]),
    .ker_we(ker_we[1]), .ker_idx(ker_idx[1]), .w_we(w_we[1]), .w_idx(w_idx[1]),
    .conv_go(conv_go[1]), .conv_pos(conv_pos[1]), .conv_img(conv_img[1]),
    .pool_go(pool_go[1]), .pool_quad(pool_quad[1]), .pool_img(pool_img[1]),
    .fc_go(fc_go[1]), .dist_go(dist_go[1]), .out_valid(out_valid[1]), .out_data(out_data[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cl_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int tl_of(input int d);
    return (d == 0) ? 3 : 2;
  endfunction

  task automatic check(input string name, input int d, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d cycle=%0d actual=0x%0h required=0x%0h", name, d, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int k, input int c, input logic [14:0] pay);
    exp_t e;
    e.cyc = c;
    e.pay = pay;
    q[d][k].push_back(e);
  endtask

  // Reference: what each beat of a frame must eventually produce, and when
  task automatic model_beat(input int d, input int k, input int c, input logic [9:0] dv);
    int   pix, row, col, cr, cc, quad, lat;
    logic sel;
    lat = cl_of(d);
    sel = (k >= 36);
    pix = k % 36;
    row = pix / 6;
    col = pix % 6;
    push(d, K_WR, c, {sel, 3'(row), 3'(col), 1'(k < 9), 4'((k < 9) ? k : 0),
                      1'(k < 4), 2'((k < 4) ? k : 0)});
    if (row >= 2 && col >= 2) begin
      cr = row - 2;
      cc = col - 2;
      push(d, K_CONV, c + 1, 15'({4'(cr * 4 + cc), sel}));
      if ((cr % 2 == 1) && (cc % 2 == 1)) begin
        quad = (cr / 2) * 2 + cc / 2;
        push(d, K_POOL, c + 1 + lat, 15'({2'(quad), sel}));
        if (quad == 3) begin
          push(d, K_FC, c + 1 + lat, 15'(sel));
          if (sel) push(d, K_DIST, c + 2 + lat, 15'(0));
        end
      end
    end
    if (k == 71) push(d, K_OUT, c + 1 + lat + tl_of(d), 15'(dv));
  endtask

  task automatic purge_after(input int r);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 6; k++)
        for (int i = q[d][k].size() - 1; i >= 0; i--)
          if (q[d][k][i].cyc > r) q[d][k].delete(i);
  endtask

  task automatic pop_cmp(input int d, input int k, input string name, input logic fire,
                         input bit has_pay, input logic [14:0] act);
    exp_t e;
    if (!fire) return;
    if (q[d][k].size() == 0) begin
      check({name, "_spurious"}, d, 64'(1), 64'(0));
      return;
    end
    e = q[d][k].pop_front();
    check({name, "_cycle"}, d, 64'(cyc), 64'(e.cyc));
    if (has_pay) check({name, "_data"}, d, 64'(act), 64'(e.pay));
  endtask

  task automatic monitor_dut(input int d);
    pop_cmp(d, K_WR, "write", img_we[d], 1'b1,
            {img_sel[d], img_row[d], img_col[d], ker_we[d], ker_idx[d], w_we[d], w_idx[d]});
    if (!img_we[d]) check("we_idle", d, 64'({ker_we[d], w_we[d]}), 64'(0));
    pop_cmp(d, K_CONV, "conv", conv_go[d], 1'b1, 15'({conv_pos[d], conv_img[d]}));
    pop_cmp(d, K_POOL, "pool", pool_go[d], 1'b1, 15'({pool_quad[d], pool_img[d]}));
    pop_cmp(d, K_FC, "fc", fc_go[d], 1'b1, 15'(pool_img[d]));
    pop_cmp(d, K_DIST, "dist", dist_go[d], 1'b0, 15'(0));
    pop_cmp(d, K_OUT, "out", out_valid[d], 1'b1, 15'(out_data[d]));
    if (!out_valid[d]) check("out_data_idle", d, 64'(out_data[d]), 64'(0));
  endtask

  always @(negedge clk) begin
    if (mon_en) for (int d = 0; d < 2; d++) monitor_dut(d);
  end

  task automatic check_all_zero(input string name);
    for (int d = 0; d < 2; d++)
      check(name, d, 64'({img_we[d], img_sel[d], img_row[d], img_col[d], ker_we[d], ker_idx[d],
                          w_we[d], w_idx[d], conv_go[d], conv_pos[d], conv_img[d], pool_go[d],
                          pool_quad[d], pool_img[d], fc_go[d], dist_go[d], out_valid[d],
                          out_data[d]}), 64'(0));
  endtask

  task automatic run_frame(input int d, input int gap_at, input int gap_len, input bit rnd_gaps,
                           input logic [9:0] dv, output int t_last);
    dist_in[d] = dv;
    t_last = 0;
    for (int k = 0; k < 72; k++) begin
      if (k == gap_at) repeat (gap_len) begin iv[d] = 1'b0; tick(); end
      if (rnd_gaps && $urandom_range(3) == 0) begin iv[d] = 1'b0; tick(); end
      iv[d] = 1'b1;
      model_beat(d, k, cyc, dv);
      t_last = cyc;
      tick();
    end
    iv[d] = 1'b0;
  endtask

  // Advance to the first cycle a new frame may start; optionally drive ignored beats meanwhile
  task automatic settle(input int d, input int t_last, input bit junk);
    while (cyc < t_last + cl_of(d) + tl_of(d) + 2) begin
      iv[d] = junk;
      tick();
    end
    iv[d] = 1'b0;
  endtask

  function automatic logic [9:0] rnd_dist();
    return 10'($urandom_range(1023));
  endfunction

  initial begin
    int t;
    rst = 1'b1;
    iv = '0;
    dist_in = '0;
    tick();
    tick();
    @(negedge clk);
    check_all_zero("reset_held");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_released");
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    run_frame(0, -1, 0, 1'b0, 10'd357, t);
    settle(0, t, 1'b0);

    run_frame(0, 21, 3, 1'b0, rnd_dist(), t);
    settle(0, t, 1'b1);

    run_frame(0, -1, 0, 1'b0, rnd_dist(), t);
    while (cyc < t + 2) tick();
    rst = 1'b1;
    purge_after(cyc);
    tick();
    rst = 1'b0;

    run_frame(0, -1, 0, 1'b1, rnd_dist(), t);
    settle(0, t, 1'b1);
    repeat (2) begin
      run_frame(0, -1, 0, 1'b1, rnd_dist(), t);
      settle(0, t, 1'b1);
    end

    run_frame(1, -1, 0, 1'b0, rnd_dist(), t);
    settle(1, t, 1'b0);
    run_frame(1, -1, 0, 1'b1, rnd_dist(), t);
    settle(1, t, 1'b1);
    run_frame(1, 10, 2, 1'b0, rnd_dist(), t);
    settle(1, t, 1'b0);

    repeat (10) tick();
    mon_en = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 6; k++)
        check("leftover_expected", d, 64'(q[d][k].size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
